// File: rtl/dmi_jtag_dtm.sv
// dmi_jtag_dtm: RISC-V debug v0.13 JTAG DTM. JTAG pins are oversampled in the
// clk domain, the 1149.1 TAP runs on the synchronised tck edges, and DMI
// Update-DR scans become single-cycle requests on the DMI bus.
// Optional feature macro: DTM_IDCODE_EN (IDCODE instruction present; when
// undefined, IR code 01 is BYPASS and the reset/TLR instruction is 5'h1F).
`timescale 1ns/1ps

module dmi_jtag_dtm #(
    parameter int unsigned ABITS       = 7,
    parameter logic [31:0] IDCODE      = 32'h1000_0B3F,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RESP_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             tdo_en,
    output logic [ABITS-1:0] dmi_address,
    output logic [31:0]      dmi_writedata,
    output logic             dmi_read,
    output logic             dmi_write,
    output logic             dmi_ready,
    input  logic [31:0]      dmi_readdata,
    output logic             dtm_busy
);

    localparam int unsigned DRW = ABITS + 34;
    localparam int unsigned CW  = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

`ifdef DTM_IDCODE_EN
    localparam logic [4:0] IR_RESET = 5'h01;
`else
    localparam logic [4:0] IR_RESET = 5'h1F;
`endif

    typedef enum logic [3:0] {
        TAP_RESET, TAP_IDLE,
        TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR,
        TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR,
        TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR,
        TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {
        REQ_IDLE, REQ_SEND, REQ_WAIT
    } req_state_t;

    typedef enum logic [1:0] {
        SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI
    } dr_sel_t;

    // ---------------------------------------------------------------
    // Pin synchronisers and tck edge detection
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
    logic                   tck_prev;
    logic                   tck_s, tms_s, tdi_s;
    logic                   tck_rise, tck_fall;

    assign tck_s    = tck_sync[SYNC_STAGES-1];
    assign tms_s    = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev;
    assign tck_fall = ~tck_s & tck_prev;

    // Shift the JTAG pins through equal-depth chains so tms/tdi stay aligned with tck
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_prev <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
            tck_prev <= tck_s;
        end
    end

    // ---------------------------------------------------------------
    // TAP controller
    // ---------------------------------------------------------------
    tap_state_t tap_state, tap_next;

    // TAP state register, advanced once per synchronised tck rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tap_state <= TAP_RESET;
        else if (tck_rise) tap_state <= tap_next;
    end

    // Standard 1149.1 next-state table
    always_comb begin
        tap_next = tap_state;
        case (tap_state)
            TAP_RESET:    tap_next = tms_s ? TAP_RESET    : TAP_IDLE;
            TAP_IDLE:     tap_next = tms_s ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_DR:   tap_next = tms_s ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   tap_next = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: tap_next = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: tap_next = tms_s ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: tap_next = tms_s ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: tap_next = tms_s ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   tap_next = tms_s ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_IR:   tap_next = tms_s ? TAP_RESET    : TAP_CAP_IR;
            TAP_CAP_IR:   tap_next = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: tap_next = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: tap_next = tms_s ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: tap_next = tms_s ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: tap_next = tms_s ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   tap_next = tms_s ? TAP_SEL_DR   : TAP_IDLE;
            default:      tap_next = TAP_RESET;
        endcase
    end

    // ---------------------------------------------------------------
    // Instruction / data registers
    // ---------------------------------------------------------------
    logic [4:0]       ir, ir_shift;
    logic [DRW-1:0]   dr_shift, dr_capture, dr_shifted;
    dr_sel_t          dr_sel;

    logic [1:0]       dmistat;
    logic [ABITS-1:0] last_addr;
    logic [31:0]      last_data;
    logic [31:0]      dtmcs_val;
    logic [31:0]      resp_data, cap_data;
    logic [1:0]       cap_status;

    req_state_t       req_state, req_next;
    logic [CW-1:0]    wait_cnt;
    logic [ABITS-1:0] req_addr;
    logic [31:0]      req_data;
    logic [1:0]       req_op;
    logic             busy, resp_done;

    // Instruction decode to the selected data register
    always_comb begin
        dr_sel = SEL_BYPASS;
        case (ir)
`ifdef DTM_IDCODE_EN
            5'h01:   dr_sel = SEL_IDCODE;
`endif
            5'h10:   dr_sel = SEL_DTMCS;
            5'h11:   dr_sel = SEL_DMI;
            default: dr_sel = SEL_BYPASS;
        endcase
    end

    assign dtmcs_val = {14'd0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat, 6'(ABITS), 4'd1};

    // A Capture-DR coinciding with the response edge sees the completed
    // transaction, so capture uses the post-response data and status.
    assign busy       = (req_state != REQ_IDLE);
    assign resp_done  = (req_state == REQ_WAIT) && (wait_cnt == '0);
    assign resp_data  = (req_op == OP_READ) ? dmi_readdata : req_data;
    assign cap_data   = resp_done ? resp_data : last_data;
    assign cap_status = (dmistat != 2'd0) ? dmistat :
                        ((busy && !resp_done) ? 2'd3 : 2'd0);

    // Capture value of the selected data register
    always_comb begin
        dr_capture = '0;
        case (dr_sel)
            SEL_IDCODE: dr_capture[31:0] = IDCODE;
            SEL_DTMCS:  dr_capture[31:0] = dtmcs_val;
            SEL_DMI:    dr_capture = {last_addr, cap_data, cap_status};
            default:    dr_capture = '0;
        endcase
    end

    // One shift step: tdi enters at the MSB of the selected register length
    always_comb begin
        dr_shifted = dr_shift >> 1;
        case (dr_sel)
            SEL_DMI:               dr_shifted[DRW-1] = tdi_s;
            SEL_IDCODE, SEL_DTMCS: dr_shifted[31]    = tdi_s;
            default:               dr_shifted[0]     = tdi_s;
        endcase
    end

    // IR/DR capture-shift-update on tck rise; tdo and its enable on tck fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= IR_RESET;
            ir_shift <= '0;
            dr_shift <= '0;
            tdo      <= 1'b0;
            tdo_en   <= 1'b0;
        end else begin
            if (tap_state == TAP_RESET) ir <= IR_RESET;
            if (tck_rise) begin
                case (tap_state)
                    TAP_CAP_IR:   ir_shift <= 5'b00001;
                    TAP_SHIFT_IR: ir_shift <= {tdi_s, ir_shift[4:1]};
                    TAP_UPD_IR:   ir       <= ir_shift;
                    TAP_CAP_DR:   dr_shift <= dr_capture;
                    TAP_SHIFT_DR: dr_shift <= dr_shifted;
                    default:      ;
                endcase
            end
            if (tck_fall) begin
                tdo    <= (tap_state == TAP_SHIFT_IR) ? ir_shift[0] : dr_shift[0];
                tdo_en <= (tap_state == TAP_SHIFT_IR) || (tap_state == TAP_SHIFT_DR);
            end
        end
    end

    // ---------------------------------------------------------------
    // Update-DR decoding and DMI request FSM
    // ---------------------------------------------------------------
    logic             upd_dr, dmi_update, dtmcs_update;
    logic             hard_reset, stat_clear, launch, overrun;
    logic [1:0]       scan_op;
    logic [31:0]      scan_data;
    logic [ABITS-1:0] scan_addr;

    assign scan_op      = dr_shift[1:0];
    assign scan_data    = dr_shift[33:2];
    assign scan_addr    = dr_shift[DRW-1:34];
    assign upd_dr       = tck_rise && (tap_state == TAP_UPD_DR);
    assign dmi_update   = upd_dr && (dr_sel == SEL_DMI);
    assign dtmcs_update = upd_dr && (dr_sel == SEL_DTMCS);
    assign hard_reset   = dtmcs_update && dr_shift[17];
    assign stat_clear   = dtmcs_update && dr_shift[16];
    assign launch       = dmi_update && (dmistat == 2'd0) && !busy &&
                          ((scan_op == OP_READ) || (scan_op == OP_WRITE));
    assign overrun      = dmi_update && (dmistat == 2'd0) && busy;

    assign dmi_address   = req_addr;
    assign dmi_writedata = req_data;

    // Request FSM next state and strobe outputs
    always_comb begin
        req_next  = req_state;
        dmi_ready = 1'b0;
        dmi_read  = 1'b0;
        dmi_write = 1'b0;
        dtm_busy  = (req_state != REQ_IDLE);
        case (req_state)
            REQ_IDLE: if (launch) req_next = REQ_SEND;
            REQ_SEND: begin
                dmi_ready = 1'b1;
                dmi_read  = (req_op == OP_READ);
                dmi_write = (req_op == OP_WRITE);
                req_next  = REQ_WAIT;
            end
            REQ_WAIT: if (wait_cnt == '0) req_next = REQ_IDLE;
            default:  req_next = REQ_IDLE;
        endcase
        if (hard_reset) req_next = REQ_IDLE;
    end

    // Request state, latency counter, request/result registers and sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_state <= REQ_IDLE;
            wait_cnt  <= '0;
            req_addr  <= '0;
            req_data  <= '0;
            req_op    <= 2'd0;
            last_addr <= '0;
            last_data <= '0;
            dmistat   <= 2'd0;
        end else begin
            req_state <= req_next;
            if (req_state == REQ_SEND) wait_cnt <= CW'(RESP_LAT - 1);
            else if ((req_state == REQ_WAIT) && (wait_cnt != '0)) wait_cnt <= wait_cnt - CW'(1);
            if (launch) begin
                req_addr  <= scan_addr;
                req_data  <= scan_data;
                req_op    <= scan_op;
                last_addr <= scan_addr;
            end
            if (resp_done && !hard_reset) last_data <= resp_data;
            if (hard_reset || stat_clear) dmistat <= 2'd0;
            else if (overrun) dmistat <= 2'd3;
        end
    end

endmodule

// File: tb/tb_dmi_jtag_dtm.sv
// tb_dmi_jtag_dtm: drives JTAG scans into dmi_jtag_dtm, checks scanned-out
// registers directly and DMI requests through an expected-request queue.
`timescale 1ns/1ps

module tb_dmi_jtag_dtm;

    localparam int unsigned ABITS = 7;
    localparam int unsigned RL    = 600;
    localparam int unsigned H     = 5;
    localparam logic [31:0] IDC   = 32'h1000_0B3F;
    localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst, tck, tms, tdi, tdo, tdo_en;
    logic [6:0]  dmi_address;
    logic [31:0] dmi_writedata, dmi_readdata;
    logic        dmi_read, dmi_write, dmi_ready, dtm_busy;

    dmi_jtag_dtm #(.ABITS(ABITS), .IDCODE(IDC), .SYNC_STAGES(2), .RESP_LAT(RL)) dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi),
        .tdo(tdo), .tdo_en(tdo_en),
        .dmi_address(dmi_address), .dmi_writedata(dmi_writedata),
        .dmi_read(dmi_read), .dmi_write(dmi_write), .dmi_ready(dmi_ready),
        .dmi_readdata(dmi_readdata), .dtm_busy(dtm_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       rd;
        logic       wr;
        logic [6:0] addr;
        logic [31:0] data;
    } exp_req_t;

    exp_req_t exp_q[$];

    task automatic push_req(input logic rd, input logic wr, input logic [6:0] addr, input logic [31:0] data);
        exp_req_t e;
        e.rd = rd; e.wr = wr; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    // DMI request monitor: every strobe must match the oldest expected request
    always @(negedge clk) begin
        exp_req_t e;
        if (dmi_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("req_read", dmi_read, e.rd);
                check("req_write", dmi_write, e.wr);
                check("req_addr", dmi_address, e.addr);
                if (e.wr) check("req_wdata", dmi_writedata, e.data);
            end
        end
    end

    // DM response model: readdata is valid only RL cycles after the strobe
    logic [31:0] resp_val = 32'h0;
    int          resp_cnt = 0;
    always @(negedge clk) begin
        if (dmi_ready === 1'b1) begin
            resp_cnt     = RL;
            dmi_readdata = JUNK;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            dmi_readdata = (resp_cnt == 0) ? resp_val : JUNK;
        end else begin
            dmi_readdata = JUNK;
        end
    end

    task automatic jtag_clk(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic en_v);
        tms = tms_v;
        tdi = tdi_v;
        repeat (H) @(negedge clk);
        tdo_v = tdo;
        en_v  = tdo_en;
        tck   = 1'b1;
        repeat (H) @(negedge clk);
        tck   = 1'b0;
    endtask

    task automatic tap_reset();
        logic b, e;
        repeat (5) jtag_clk(1'b1, 1'b0, b, e);
        jtag_clk(1'b0, 1'b0, b, e);
    endtask

    // From Run-Test/Idle: load IR, return to Run-Test/Idle
    task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
        logic b, e;
        jtag_clk(1'b1, 1'b0, b, e);
        jtag_clk(1'b1, 1'b0, b, e);
        jtag_clk(1'b0, 1'b0, b, e);
        jtag_clk(1'b0, 1'b0, b, e);
        for (int i = 0; i < 5; i++) begin
            jtag_clk(i == 4, din[i], b, e);
            dout[i] = b;
        end
        jtag_clk(1'b1, 1'b0, b, e);
        jtag_clk(1'b0, 1'b0, b, e);
    endtask

    // From Run-Test/Idle: capture, shift n bits LSB first, update, back to idle
    task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic b, e, en_ok;
        dout  = '0;
        en_ok = 1'b1;
        jtag_clk(1'b1, 1'b0, b, e);
        jtag_clk(1'b0, 1'b0, b, e);
        jtag_clk(1'b0, 1'b0, b, e);
        for (int i = 0; i < n; i++) begin
            jtag_clk(i == n - 1, din[i], b, e);
            dout[i] = b;
            if (e !== 1'b1) en_ok = 1'b0;
        end
        jtag_clk(1'b1, 1'b0, b, e);
        jtag_clk(1'b0, 1'b0, b, e);
        check("shift_tdo_en", en_ok, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (dtm_busy === 1'b1 && k < int'(RL) + 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, dtm_busy, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, dtm_busy, 0);
        check({tag, "_strobes"}, {dmi_ready, dmi_read, dmi_write}, 0);
        check({tag, "_addr"}, dmi_address, 0);
        check({tag, "_wdata"}, dmi_writedata, 0);
        check({tag, "_tdo"}, {tdo, tdo_en}, 0);
    endtask

    function automatic logic [31:0] post_reset_dr(input logic [31:0] din);
`ifdef DTM_IDCODE_EN
        return IDC;
`else
        return {din[30:0], 1'b0};
`endif
    endfunction

    initial begin
        logic [63:0] d;
        logic [4:0]  ir_out;
        logic [31:0] pat;

        rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // IDCODE (or bypass) after reset
        tap_reset();
        pat = 32'h5A3C_96E1;
        scan_dr({32'h0, pat}, 32, d);
        check("idcode_after_reset", d, {32'h0, post_reset_dr(pat)});
        repeat (H) @(negedge clk);
        check("tdo_en_idle", tdo_en, 0);

        // IR capture pattern, DTMCS, bypass
        scan_ir(5'h10, ir_out);
        check("ir_capture", ir_out, 5'b00001);
        scan_dr(64'h0, 32, d);
        check("dtmcs", d, 64'h0000_1071);
        scan_ir(5'h1F, ir_out);
        scan_dr(64'hB, 4, d);
        check("bypass", d, 64'h6);

        // DMI write
        scan_ir(5'h11, ir_out);
        push_req(1'b0, 1'b1, 7'h10, 32'h8000_0000);
        scan_dr({7'h10, 32'h8000_0000, 2'd2}, 41, d);
        check("dmi_cap_initial", d, 0);
        check("busy_after_write", dtm_busy, 1);
        wait_idle("idle_write1");

        // DMI read, then a nop scan to collect the data
        resp_val = 32'h0000_0082;
        push_req(1'b1, 1'b0, 7'h11, 32'h0);
        scan_dr({7'h11, 32'h0, 2'd1}, 41, d);
        check("dmi_cap_after_write", d, {7'h10, 32'h8000_0000, 2'd0});
        wait_idle("idle_read");
        scan_dr({7'h11, 32'h0, 2'd0}, 41, d);
        check("dmi_read_data", d, {7'h11, 32'h0000_0082, 2'd0});
        check("nop_not_busy", dtm_busy, 0);

        // Back-to-back writes: second scan sees busy and trips sticky status
        push_req(1'b0, 1'b1, 7'h20, 32'h1111_2222);
        scan_dr({7'h20, 32'h1111_2222, 2'd2}, 41, d);
        check("dmi_cap_before_b2b", d, {7'h11, 32'h0000_0082, 2'd0});
        scan_dr({7'h21, 32'h3333_4444, 2'd2}, 41, d);
        check("dmi_cap_busy", d, {7'h20, 32'h0000_0082, 2'd3});
        wait_idle("idle_b2b");
        scan_dr({7'h22, 32'h5555_6666, 2'd2}, 41, d);
        check("dmi_cap_sticky", d, {7'h20, 32'h1111_2222, 2'd3});
        check("ignored_not_busy", dtm_busy, 0);

        // Clear dmistat through DTMCS.dmireset, then a new op is accepted
        scan_ir(5'h10, ir_out);
        scan_dr(64'h0001_0000, 32, d);
        check("dtmcs_dmistat3", d, 64'h0000_1C71);
        scan_dr(64'h0, 32, d);
        check("dtmcs_cleared", d, 64'h0000_1071);
        scan_ir(5'h11, ir_out);
        push_req(1'b0, 1'b1, 7'h23, 32'hCAFE_F00D);
        scan_dr({7'h23, 32'hCAFE_F00D, 2'd2}, 41, d);
        check("dmi_cap_after_clear", d, {7'h20, 32'h1111_2222, 2'd0});
        check("busy_after_clear", dtm_busy, 1);

        // Reset while waiting for the response
        repeat (3) @(negedge clk);
        check("in_wait_before_rst", dtm_busy, 1);
        rst = 1'b1;
        tms = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        begin
            logic b, e;
            jtag_clk(1'b0, 1'b0, b, e);
        end
        pat = 32'hC3A5_0F1E;
        scan_dr({32'h0, pat}, 32, d);
        check("ir_after_rst", d, {32'h0, post_reset_dr(pat)});

        repeat (RL + 50) @(negedge clk);
        check("all_requests_seen", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
